sram_arbiter: RTL and testbench

- Request arbiter directly upstream of the SRAM controller. It merges two sources into the controller's single-access handshake (Begin/Write/Addr/Data in, Ready/Data out):
  - a pixel-write stream from the fractal engine, buffered in a small FIFO;
  - a read-request stream from the LCD scan-out prefetcher.
- Reads have priority, because the LCD path is latency-critical. Read data is returned with a one-cycle valid pulse.

---
 rtl/sram_arbiter.sv | 142 ++++++++++++++
 tb/tb_sram_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: merges a FIFO-buffered pixel-write stream and LCD read requests onto the SRAM controller handshake.
// Define ARB_STARVE_GUARD_EN to force a write grant after three read grants that bypassed a pending write.
module sram_arbiter #(
    parameter int WFIFO_AW = 2,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 16
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_Wr_Valid,
    input  logic [ADDR_W-1:0] i_Wr_Addr,
    input  logic [DATA_W-1:0] i_Wr_Data,
    output logic              o_Wr_Ready,
    input  logic              i_Rd_Req,
    input  logic [ADDR_W-1:0] i_Rd_Addr,
    output logic              o_Rd_Ready,
    output logic              o_Rd_Valid,
    output logic [DATA_W-1:0] o_Rd_Data,
    output logic              o_Idle,
    output logic              o_SRAM_Begin,
    output logic              o_SRAM_Write,
    output logic [ADDR_W-1:0] o_SRAM_Addr,
    output logic [DATA_W-1:0] o_SRAM_Data,
    input  logic [DATA_W-1:0] i_SRAM_Data,
    input  logic              i_SRAM_Ready
);
    localparam int DEPTH = 1 << WFIFO_AW;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  fifo_addr_q [DEPTH];
    logic [DATA_W-1:0]  fifo_data_q [DEPTH];
    logic [WFIFO_AW:0]  wptr_q, rptr_q, wptr_d, rptr_d;
    logic               fifo_empty, fifo_full, push;
    logic               rd_grant, wr_grant, arb_open, force_wr;
    logic               begin_q, write_q, rd_valid_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q, rd_data_q;

    // Extra pointer MSB tells a full FIFO apart from an empty one.
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[WFIFO_AW] != rptr_q[WFIFO_AW]) &&
                        (wptr_q[WFIFO_AW-1:0] == rptr_q[WFIFO_AW-1:0]);
    assign push       = i_Wr_Valid && !fifo_full;

`ifdef ARB_STARVE_GUARD_EN
    logic [1:0] starve_cnt_q;

    assign force_wr = (starve_cnt_q == 2'd3) && !fifo_empty;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            starve_cnt_q <= 2'd0;
        end else if (wr_grant) begin
            starve_cnt_q <= 2'd0;
        end else if (rd_grant && !fifo_empty) begin
            starve_cnt_q <= starve_cnt_q + 2'd1;
        end
    end
`else
    assign force_wr = 1'b0;
`endif

    assign arb_open   = (state_q == S_IDLE) && i_SRAM_Ready;
    assign o_Rd_Ready = arb_open && !force_wr;
    assign rd_grant   = o_Rd_Ready && i_Rd_Req;
    assign wr_grant   = arb_open && !fifo_empty && !rd_grant;

    assign wptr_d = wptr_q + {{WFIFO_AW{1'b0}}, push};
    assign rptr_d = rptr_q + {{WFIFO_AW{1'b0}}, wr_grant};

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (push) begin
            fifo_addr_q[wptr_q[WFIFO_AW-1:0]] <= i_Wr_Addr;
            fifo_data_q[wptr_q[WFIFO_AW-1:0]] <= i_Wr_Data;
        end
    end

    // S_IDLE arbitrates, S_ISSUE carries the Begin pulse, S_WAIT holds until the controller is Ready.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q    <= S_IDLE;
            begin_q    <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            begin_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rd_grant) begin
                        addr_q  <= i_Rd_Addr;
                        write_q <= 1'b0;
                        begin_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end else if (wr_grant) begin
                        addr_q  <= fifo_addr_q[rptr_q[WFIFO_AW-1:0]];
                        data_q  <= fifo_data_q[rptr_q[WFIFO_AW-1:0]];
                        write_q <= 1'b1;
                        begin_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (i_SRAM_Ready) begin
                        state_q <= S_IDLE;
                        if (!write_q) begin
                            rd_data_q  <= i_SRAM_Data;
                            rd_valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_Wr_Ready   = !fifo_full;
    assign o_Rd_Valid   = rd_valid_q;
    assign o_Rd_Data    = rd_data_q;
    assign o_Idle       = (state_q == S_IDLE) && fifo_empty && i_SRAM_Ready;
    assign o_SRAM_Begin = begin_q;
    assign o_SRAM_Write = write_q;
    assign o_SRAM_Addr  = addr_q;
    assign o_SRAM_Data  = data_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM controller (Ready low for two cycles after Begin).
`timescale 1ns/1ps
module tb_sram_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid, wr_ready, rd_req, rd_ready, rd_valid, idle;
    logic [18:0] wr_addr, rd_addr, s_addr;
    logic [15:0] wr_data, rd_data, s_data_o, s_data_i;
    logic        s_begin, s_write, s_ready;
    logic        ctl_hold;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .i_CLK(clk), .i_RST(rst),
        .i_Wr_Valid(wr_valid), .i_Wr_Addr(wr_addr), .i_Wr_Data(wr_data), .o_Wr_Ready(wr_ready),
        .i_Rd_Req(rd_req), .i_Rd_Addr(rd_addr), .o_Rd_Ready(rd_ready),
        .o_Rd_Valid(rd_valid), .o_Rd_Data(rd_data), .o_Idle(idle),
        .o_SRAM_Begin(s_begin), .o_SRAM_Write(s_write), .o_SRAM_Addr(s_addr),
        .o_SRAM_Data(s_data_o), .i_SRAM_Data(s_data_i), .i_SRAM_Ready(s_ready)
    );

    function automatic logic [15:0] rd_model(input logic [18:0] a);
        return (a == 19'h7FFFF) ? 16'h1234 : (a[15:0] ^ 16'hA5A5);
    endfunction

    // Controller model: never reset, like the real controller.
    logic [1:0]  busy_q  = 2'd0;
    logic [15:0] rdata_q = 16'h0;
    int          cyc       = 0;
    int          proto_err = 0;
    int          rv_cnt    = 0;
    bit          log_wr[$];
    logic [18:0] log_addr[$];
    logic [15:0] log_data[$];
    int          log_cyc[$];

    assign s_ready  = (busy_q == 2'd0) && !ctl_hold;
    assign s_data_i = rdata_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_valid) rv_cnt <= rv_cnt + 1;
        if (s_begin) begin
            if (!s_ready) proto_err <= proto_err + 1;
            busy_q  <= 2'd2;
            rdata_q <= rd_model(s_addr);
            log_wr.push_back(s_write);
            log_addr.push_back(s_addr);
            log_data.push_back(s_data_o);
            log_cyc.push_back(cyc);
        end else if (busy_q != 2'd0) begin
            busy_q <= busy_q - 2'd1;
        end
    end

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (idle) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 0; wr_addr = '0; wr_data = '0; rd_req = 0; rd_addr = '0; ctl_hold = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (s_begin !== 1'b0)   begin n_fail++; $display("FAIL reset_begin: got %b want 0", s_begin); end
        n_checks++; if (s_write !== 1'b0)   begin n_fail++; $display("FAIL reset_write: got %b want 0", s_write); end
        n_checks++; if (rd_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_checks++; if (s_addr !== 19'h0)   begin n_fail++; $display("FAIL reset_addr: got %h want 0", s_addr); end
        n_checks++; if (s_data_o !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", s_data_o); end
        n_checks++; if (rd_data !== 16'h0)  begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_checks++; if (wr_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_single_write();
        int base = log_wr.size();
        @(negedge clk); wr_valid = 1; wr_addr = 19'h00010; wr_data = 16'hBEEF;
        @(posedge clk); #1; wr_valid = 0;
        @(posedge clk); #1;
        n_checks++; if (s_begin !== 1'b1)        begin n_fail++; $display("FAIL wr_begin: got %b want 1", s_begin); end
        n_checks++; if (s_write !== 1'b1)        begin n_fail++; $display("FAIL wr_write: got %b want 1", s_write); end
        n_checks++; if (s_addr !== 19'h00010)    begin n_fail++; $display("FAIL wr_addr: got %h want 00010", s_addr); end
        n_checks++; if (s_data_o !== 16'hBEEF)   begin n_fail++; $display("FAIL wr_data: got %h want beef", s_data_o); end
        @(posedge clk); #1;
        n_checks++; if (s_begin !== 1'b0)        begin n_fail++; $display("FAIL wr_begin_pulse: got %b want 0", s_begin); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (idle !== 1'b0)           begin n_fail++; $display("FAIL wr_idle_4: got %b want 0", idle); end
        @(posedge clk); #1;
        n_checks++; if (idle !== 1'b1)           begin n_fail++; $display("FAIL wr_idle_5: got %b want 1", idle); end
        n_checks++; if (log_wr.size() - base != 1) begin n_fail++; $display("FAIL wr_issue_count: got %0d want 1", log_wr.size() - base); end
    endtask

    task automatic test_single_read();
        int lat = 0;
        @(negedge clk); rd_req = 1; rd_addr = 19'h7FFFF;
        n_checks++; if (rd_ready !== 1'b1)       begin n_fail++; $display("FAIL rd_ready_idle: got %b want 1", rd_ready); end
        @(posedge clk); #1; rd_req = 0;
        n_checks++; if (s_begin !== 1'b1 || s_write !== 1'b0 || s_addr !== 19'h7FFFF)
            begin n_fail++; $display("FAIL rd_issue: got begin=%b write=%b addr=%h want 1 0 7ffff", s_begin, s_write, s_addr); end
        n_checks++; if (rd_ready !== 1'b0)       begin n_fail++; $display("FAIL rd_ready_issue: got %b want 0", rd_ready); end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (rd_valid) begin lat = k; break; end
        end
        n_checks++; if (lat != 4)                begin n_fail++; $display("FAIL rd_latency: got %0d want 4", lat); end
        n_checks++; if (rd_data !== 16'h1234)    begin n_fail++; $display("FAIL rd_data: got %h want 1234", rd_data); end
        @(posedge clk); #1;
        n_checks++; if (rd_valid !== 1'b0)       begin n_fail++; $display("FAIL rd_valid_pulse: got %b want 0", rd_valid); end
    endtask

    task automatic test_rd_wr_same_cycle();
        int base = log_wr.size();
        bit ok;
        @(negedge clk); ctl_hold = 1; wr_valid = 1; wr_addr = 19'h00AAA; wr_data = 16'h5555;
        @(posedge clk); #1; wr_valid = 0;
        @(negedge clk); rd_req = 1; rd_addr = 19'h00123; ctl_hold = 0;
        @(posedge clk); #1; rd_req = 0;
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rw_idle_timeout: got busy want idle"); end
        n_checks++; if (log_wr.size() - base != 2) begin n_fail++; $display("FAIL rw_count: got %0d want 2", log_wr.size() - base); end
        else begin
            n_checks++; if (log_wr[base] !== 1'b0 || log_addr[base] !== 19'h00123)
                begin n_fail++; $display("FAIL rw_first: got wr=%b addr=%h want read 00123", log_wr[base], log_addr[base]); end
            n_checks++; if (log_wr[base+1] !== 1'b1 || log_addr[base+1] !== 19'h00AAA || log_data[base+1] !== 16'h5555)
                begin n_fail++; $display("FAIL rw_second: got wr=%b addr=%h data=%h want write 00aaa 5555", log_wr[base+1], log_addr[base+1], log_data[base+1]); end
            n_checks++; if (log_cyc[base+1] - log_cyc[base] != 5)
                begin n_fail++; $display("FAIL rw_spacing: got %0d want 5", log_cyc[base+1] - log_cyc[base]); end
        end
    endtask

    task automatic test_fifo_full();
        int base = log_wr.size();
        bit ok;
        @(negedge clk); ctl_hold = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); wr_valid = 1; wr_addr = 19'h00100 + 19'(i); wr_data = 16'h1000 + 16'(i);
            n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fifo_ready_%0d: got %b want 1", i, wr_ready); end
            @(posedge clk);
        end
        #1;
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL fifo_full: got %b want 0", wr_ready); end
        @(negedge clk); wr_addr = 19'h00104; wr_data = 16'h1004;
        @(posedge clk); #1;
        n_checks++; if (wr_ready !== 1'b0 || s_begin !== 1'b0)
            begin n_fail++; $display("FAIL fifo_held: got ready=%b begin=%b want 0 0", wr_ready, s_begin); end
        @(negedge clk); ctl_hold = 0;
        @(posedge clk); #1;
        n_checks++; if (s_begin !== 1'b1 || s_addr !== 19'h00100 || wr_ready !== 1'b1)
            begin n_fail++; $display("FAIL fifo_first_pop: got begin=%b addr=%h ready=%b want 1 00100 1", s_begin, s_addr, wr_ready); end
        @(posedge clk); #1; wr_valid = 0;
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fifo_idle_timeout: got busy want idle"); end
        n_checks++; if (log_wr.size() - base != 5) begin n_fail++; $display("FAIL fifo_count: got %0d want 5", log_wr.size() - base); end
        else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (log_wr[base+i] !== 1'b1 || log_addr[base+i] !== 19'h00100 + 19'(i) || log_data[base+i] !== 16'h1000 + 16'(i))
                    begin n_fail++; $display("FAIL fifo_order_%0d: got wr=%b addr=%h data=%h", i, log_wr[base+i], log_addr[base+i], log_data[base+i]); end
                if (i > 0) begin
                    n_checks++;
                    if (log_cyc[base+i] - log_cyc[base+i-1] != 5)
                        begin n_fail++; $display("FAIL fifo_spacing_%0d: got %0d want 5", i, log_cyc[base+i] - log_cyc[base+i-1]); end
                end
            end
        end
    endtask

    task automatic test_starvation();
        int base = log_wr.size();
        int n_wr = 0;
        bit ok;
        @(negedge clk); ctl_hold = 1; wr_valid = 1; wr_addr = 19'h00055; wr_data = 16'hCAFE;
        @(posedge clk); #1; wr_valid = 0;
        @(negedge clk); rd_req = 1; rd_addr = 19'h00100; ctl_hold = 0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        for (int i = base; i < log_wr.size(); i++) if (log_wr[i]) n_wr++;
        n_checks++; if (log_wr.size() - base != 6) begin n_fail++; $display("FAIL starve_grants: got %0d want 6", log_wr.size() - base); end
`ifdef ARB_STARVE_GUARD_EN
        n_checks++; if (n_wr != 1) begin n_fail++; $display("FAIL starve_guard_writes: got %0d want 1", n_wr); end
        if (log_wr.size() - base >= 4) begin
            n_checks++; if (log_wr[base+3] !== 1'b1 || log_addr[base+3] !== 19'h00055 || log_data[base+3] !== 16'hCAFE)
                begin n_fail++; $display("FAIL starve_guard_slot: got wr=%b addr=%h want write 00055 after 3 reads", log_wr[base+3], log_addr[base+3]); end
        end
`else
        n_checks++; if (n_wr != 0) begin n_fail++; $display("FAIL starve_strict: got %0d writes want 0", n_wr); end
`endif
        rd_req = 0;
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL starve_idle_timeout: got busy want idle"); end
        n_wr = 0;
        for (int i = base; i < log_wr.size(); i++) if (log_wr[i]) n_wr++;
        n_checks++; if (n_wr != 1) begin n_fail++; $display("FAIL starve_final_writes: got %0d want 1", n_wr); end
    endtask

    task automatic test_reset_mid_read();
        int base = log_wr.size();
        int rv0  = rv_cnt;
        int lat  = 0;
        int n_wr = 0;
        @(negedge clk); rd_req = 1; rd_addr = 19'h00200;
        @(posedge clk); #1; rd_req = 0;
        @(negedge clk); wr_valid = 1; wr_addr = 19'h00300; wr_data = 16'h3333;
        @(posedge clk);
        @(negedge clk); wr_addr = 19'h00301; wr_data = 16'h3334;
        @(posedge clk);
        @(negedge clk); wr_valid = 0; rst = 1;
        #2; rst = 0; rd_req = 1; rd_addr = 19'h00400;
        n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rd_ready_busy: got %b want 0", rd_ready); end
        @(posedge clk); #1;
        n_checks++; if (s_begin !== 1'b0) begin n_fail++; $display("FAIL rst_no_issue_busy: got %b want 0", s_begin); end
        n_checks++; if (idle !== 1'b1)    begin n_fail++; $display("FAIL rst_fifo_empty_idle: got %b want 1", idle); end
        @(posedge clk); #1; rd_req = 0;
        n_checks++; if (s_begin !== 1'b1 || s_addr !== 19'h00400 || s_write !== 1'b0)
            begin n_fail++; $display("FAIL rst_next_issue: got begin=%b addr=%h write=%b want 1 00400 0", s_begin, s_addr, s_write); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dropped_valid: got %b want 0", rd_valid); end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (rd_valid) begin lat = k; break; end
        end
        n_checks++; if (lat != 4 || rd_data !== 16'hA1A5)
            begin n_fail++; $display("FAIL rst_next_read: got lat=%0d data=%h want 4 a1a5", lat, rd_data); end
        n_checks++; if (rv_cnt - rv0 != 0) begin n_fail++; $display("FAIL rst_valid_count: got %0d want 0 before sample", rv_cnt - rv0); end
        repeat (10) @(posedge clk);
        #1;
        for (int i = base; i < log_wr.size(); i++) if (log_wr[i]) n_wr++;
        n_checks++; if (n_wr != 0 || log_wr.size() - base != 2)
            begin n_fail++; $display("FAIL rst_issue_log: got %0d writes %0d total want 0 2", n_wr, log_wr.size() - base); end
        n_checks++; if (rv_cnt - rv0 != 1) begin n_fail++; $display("FAIL rst_valid_total: got %0d want 1", rv_cnt - rv0); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_rd_wr_same_cycle();
        test_fifo_full();
        test_starvation();
        test_reset_mid_read();
        n_checks++; if (proto_err != 0) begin n_fail++; $display("FAIL begin_while_busy: got %0d want 0", proto_err); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
